// File: rtl/io_pkg.sv
// Shared I/O-space constants: address selectors, output port count and status word layout.
package io_pkg;

    localparam logic [5:0] IN_SEL_PORT0 = 6'b110000;
    localparam logic [5:0] IN_SEL_PORT1 = 6'b110001;
    localparam logic [5:0] OUT_SEL_BASE = 6'b100000;
    localparam logic [5:0] OUT_SEL_CTL  = 6'b100011;

    localparam int N_OUT_PORTS = 3;

    // Status word: {26'b0, overrun[2:0], out_valid[2:0]}
    localparam int STAT_VALID_LSB = 0;
    localparam int STAT_OVR_LSB   = 3;
    localparam int STAT_W         = 2 * N_OUT_PORTS;

    typedef enum logic {
        PORT_IDLE = 1'b0,
        PORT_PEND = 1'b1
    } port_state_e;

endpackage

// File: rtl/io_output_port.sv
// One output port: data register, valid/pending handshake with the device, sticky overrun flag.
module io_output_port
    import io_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        io_clk,
    input  logic        clrn,
    input  logic        wr,
    input  logic        ack,
    input  logic        clr_ovr,
    input  logic [31:0] din,
    output logic [31:0] data,
    output logic        valid,
    output logic        ovr
);

    port_state_e r_state;
    port_state_e w_state_next;
    logic [31:0] r_data;
    logic [31:0] w_data_next;
    logic        r_ovr;
    logic        w_ovr_next;

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= PORT_IDLE;
            r_data  <= RESET_VAL;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            r_ovr   <= w_ovr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        // Clear first so that an overrun on the same edge overrides it.
        w_ovr_next   = r_ovr & ~clr_ovr;
        case (r_state)
            PORT_IDLE: begin
                if (wr) begin
                    w_data_next  = din;
                    w_state_next = PORT_PEND;
                end
            end
            PORT_PEND: begin
                if (wr) begin
                    w_data_next = din;
                    if (!ack) begin
                        w_ovr_next = 1'b1;
                    end
                end else if (ack) begin
                    w_state_next = PORT_IDLE;
                end
            end
            default: w_state_next = PORT_IDLE;
        endcase
    end

    assign data  = r_data;
    assign valid = (r_state == PORT_PEND);
    assign ovr   = r_ovr;

endmodule

// File: rtl/io_output_reg.sv
// Memory-mapped output port bank: decodes CPU stores by addr[7:2] into three handshaked ports.
// Optional macro IO_OUTPUT_STATUS_EN adds the status_data read word.
module io_output_reg
    import io_pkg::*;
#(
    parameter logic [5:0]  OUT_SEL_BASE = io_pkg::OUT_SEL_BASE,
    parameter logic [31:0] RESET_VAL    = 32'h0000_0000
) (
    input  logic        io_clk,
    input  logic        clrn,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        write_io_enable,
    input  logic [2:0]  out_ack,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    output logic [2:0]  out_valid,
    output logic [2:0]  overrun
`ifdef IO_OUTPUT_STATUS_EN
    ,
    output logic [31:0] status_data
`endif
);

    localparam logic [5:0] SEL_CTL = OUT_SEL_BASE + 6'd3;

    logic [5:0]                  w_sel;
    logic                        w_wr_ctl;
    logic [N_OUT_PORTS-1:0]      w_wr;
    logic [N_OUT_PORTS-1:0]      w_valid;
    logic [N_OUT_PORTS-1:0]      w_ovr;
    logic [31:0]                 w_data [N_OUT_PORTS];
    logic                        w_unused_addr;

    assign w_sel         = addr[7:2];
    assign w_wr_ctl      = write_io_enable && (w_sel == SEL_CTL);
    assign w_unused_addr = ^{addr[31:8], addr[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT_PORTS; gi++) begin : g_port
            assign w_wr[gi] = write_io_enable && (w_sel == (OUT_SEL_BASE + 6'(gi)));

            io_output_port #(
                .RESET_VAL (RESET_VAL)
            ) u_port (
                .io_clk  (io_clk),
                .clrn    (clrn),
                .wr      (w_wr[gi]),
                .ack     (out_ack[gi]),
                .clr_ovr (w_wr_ctl && datain[gi]),
                .din     (datain),
                .data    (w_data[gi]),
                .valid   (w_valid[gi]),
                .ovr     (w_ovr[gi])
            );
        end
    endgenerate

    assign out_port0 = w_data[0];
    assign out_port1 = w_data[1];
    assign out_port2 = w_data[2];
    assign out_valid = w_valid;
    assign overrun   = w_ovr;

`ifdef IO_OUTPUT_STATUS_EN
    always_comb begin
        status_data = 32'h0000_0000;
        status_data[STAT_VALID_LSB +: N_OUT_PORTS] = w_valid;
        status_data[STAT_OVR_LSB   +: N_OUT_PORTS] = w_ovr;
    end
`endif

endmodule

// File: tb/tb_io_output_reg.sv
// Self-checking bench for io_output_reg: directed handshake cases, async reset, then random traffic.
module tb_io_output_reg;

    logic        io_clk;
    logic        clrn;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        write_io_enable;
    logic [2:0]  out_ack;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [31:0] out_port2;
    logic [2:0]  out_valid;
    logic [2:0]  overrun;
`ifdef IO_OUTPUT_STATUS_EN
    logic [31:0] status_data;
`endif

    io_output_reg dut (
        .io_clk          (io_clk),
        .clrn            (clrn),
        .addr            (addr),
        .datain          (datain),
        .write_io_enable (write_io_enable),
        .out_ack         (out_ack),
        .out_port0       (out_port0),
        .out_port1       (out_port1),
        .out_port2       (out_port2),
        .out_valid       (out_valid),
        .overrun         (overrun)
`ifdef IO_OUTPUT_STATUS_EN
        ,
        .status_data     (status_data)
`endif
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what each port currently holds and its flags
    logic [31:0] m_data [3];
    logic [2:0]  m_valid;
    logic [2:0]  m_ovr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_data[i] = 32'h0;
        m_valid = 3'b000;
        m_ovr   = 3'b000;
    endtask

    // Apply one rising edge of the specification's rules to the model
    task automatic model_step();
        logic [5:0] s;
        s = addr[7:2];
        for (int i = 0; i < 3; i++) begin
            bit hit;
            hit = write_io_enable && (s == 6'd32 + 6'(i));
            if (write_io_enable && s == 6'd35 && datain[i]) m_ovr[i] = 1'b0;
            if (hit && m_valid[i] && !out_ack[i]) m_ovr[i] = 1'b1;
            if (hit) begin
                m_data[i]  = datain;
                m_valid[i] = 1'b1;
            end else if (out_ack[i]) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".port0"}, out_port0, m_data[0]);
        chk({ctx, ".port1"}, out_port1, m_data[1]);
        chk({ctx, ".port2"}, out_port2, m_data[2]);
        chk({ctx, ".valid"}, {29'h0, out_valid}, {29'h0, m_valid});
        chk({ctx, ".ovr"},   {29'h0, overrun},   {29'h0, m_ovr});
`ifdef IO_OUTPUT_STATUS_EN
        chk({ctx, ".status"}, status_data, {26'h0, m_ovr, m_valid});
`endif
    endtask

    // Called right after a negedge: drive inputs for the next rising edge
    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] ack);
        write_io_enable = we;
        addr            = a;
        datain          = d;
        out_ack         = ack;
    endtask

    task automatic cycle(input string ctx);
        @(posedge io_clk);
        model_step();
        @(negedge io_clk);
        check_all(ctx);
        $display("txn %s: we=%0b addr=%h din=%h ack=%b -> valid=%b ovr=%b", ctx,
                 write_io_enable, addr, datain, out_ack, out_valid, overrun);
        drive(1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  sel;
        clrn = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        model_reset();
        repeat (2) @(negedge io_clk);
        check_all("reset");
        clrn = 1'b1;

        // Store then acknowledge on port 0
        drive(1'b1, 32'h80, 32'hDEADBEEF, 3'b000);
        cycle("st_p0");
        chk("t2.port0", out_port0, 32'hDEADBEEF);
        chk("t2.valid", {29'h0, out_valid}, 32'h1);
        drive(1'b0, 32'h0, 32'h0, 3'b001);
        cycle("ack_p0");
        chk("t2.valid_after_ack", {29'h0, out_valid}, 32'h0);
        chk("t2.port0_held", out_port0, 32'hDEADBEEF);

        // Overrun on port 1
        drive(1'b1, 32'h84, 32'h1, 3'b000);
        cycle("st_p1a");
        drive(1'b1, 32'h84, 32'h2, 3'b000);
        cycle("st_p1b");
        chk("t3.port1", out_port1, 32'h2);
        chk("t3.ovr", {29'h0, overrun}, 32'h2);

        // Store and ack on the same edge: no overrun
        drive(1'b1, 32'h88, 32'h33, 3'b000);
        cycle("st_p2a");
        drive(1'b1, 32'h88, 32'h55, 3'b100);
        cycle("st_p2b_ack");
        chk("t4.port2", out_port2, 32'h55);
        chk("t4.ovr2", {31'h0, overrun[2]}, 32'h0);
        chk("t4.valid2", {31'h0, out_valid[2]}, 32'h1);

        // Build overrun=011 then W1C bit 0
        drive(1'b1, 32'h80, 32'h10, 3'b000);
        cycle("st_p0a");
        drive(1'b1, 32'h80, 32'h11, 3'b000);
        cycle("st_p0b");
        chk("t5.ovr_pre", {29'h0, overrun}, 32'h3);
        drive(1'b1, 32'h8C, 32'hFFFF_FFF9, 3'b000);
        cycle("w1c");
        chk("t5.ovr_post", {29'h0, overrun}, 32'h2);
        drive(1'b1, 32'h90, 32'h1234, 3'b000);
        cycle("st_0x90");
        drive(1'b1, 32'hC0, 32'h5678, 3'b000);
        cycle("st_0xC0");

        // Ack port 1 only: ports 0 and 2 remain pending, overrun[1] stays
        drive(1'b0, 32'h0, 32'h0, 3'b010);
        cycle("ack_p1");
        chk("t6.valid", {29'h0, out_valid}, 32'h5);
`ifdef IO_OUTPUT_STATUS_EN
        chk("t6.status", status_data, 32'h0000_0015);
`endif

        // Asynchronous reset mid-cycle with all ports pending
        drive(1'b1, 32'h84, 32'hA5A5_A5A5, 3'b000);
        cycle("st_p1c");
        chk("rst.pre_valid", {29'h0, out_valid}, 32'h7);
        #2 clrn = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge io_clk);
        check_all("rst_hold");
        clrn = 1'b1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            case ($urandom_range(0, 7))
                0: sel = 6'h20;
                1: sel = 6'h21;
                2: sel = 6'h22;
                3: sel = 6'h23;
                4: sel = 6'h24;
                5: sel = 6'h30;
                default: sel = 6'($urandom_range(0, 63));
            endcase
            drive($urandom_range(0, 3) != 0, {r[31:8], sel, r[1:0]}, $urandom,
                  3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)));
            cycle($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
